jk_seq_ctrl: RTL and testbench

- Command-driven sequencer for a bank of W JK flip-flops.
- Accepts CLEAR, LOAD, TOGGLE and multi-step UP/DOWN count commands over a valid/ready handshake.
- Each clock, derives the per-bit JK codes that realise the command on the bank.
- Standard way to build registers and counters out of JK cells.

---
 rtl/jk_seq_pkg.sv | 14 +
 rtl/jk_cell.sv | 17 +
 rtl/jk_seq_ctrl.sv | 86 ++++++++
 tb/tb_jk_seq_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: opcodes, JK codes and FSM states shared by the JK sequencer
package jk_seq_pkg;
   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_CLEAR  = 3'b001;
   localparam logic [2:0] OP_LOAD   = 3'b010;
   localparam logic [2:0] OP_UP     = 3'b011;
   localparam logic [2:0] OP_DOWN   = 3'b100;
   localparam logic [2:0] OP_TOGGLE = 3'b101;
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single positive-edge JK flip-flop with async active-high reset to 0
module jk_cell
   import jk_seq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);
   // JK next-state: set, reset, toggle or hold
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= 1'b0;
      else q <= {j, k} == JK_SET ? 1'b1 : {j, k} == JK_RST ? 1'b0 : {j, k} == JK_TGL ? ~q : q;
   assign qbar = ~q;
endmodule

// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: command sequencer driving W JK cells; define JK_SEQ_SAT_EN for saturating UP/DOWN
module jk_seq_ctrl
   import jk_seq_pkg::*;
#(
   parameter int W  = 4,
   parameter int CW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_op,
   input  logic [W-1:0]    cmd_data,
   input  logic [CW-1:0]   cmd_count,
   output logic [W-1:0]    q,
   output logic [W-1:0]    qbar,
   output logic [2*W-1:0]  jk_mon,
   output logic            busy,
   output logic            done,
   output logic            err
);
   state_t state, state_n;
   logic [2:0] op_r;
   logic [W-1:0] data_r, ones, zeros;
   logic [CW-1:0] cnt_r;
   logic accept, direct, multi, sat_up, sat_dn;
   assign accept = cmd_valid && cmd_ready;
   assign multi = cmd_op == OP_UP || cmd_op == OP_DOWN;
   assign direct = cmd_op == OP_NOP || cmd_op > OP_TOGGLE || (multi && cmd_count == '0);
   assign cmd_ready = state == IDLE;
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign err = done && op_r > OP_TOGGLE;
`ifdef JK_SEQ_SAT_EN
   assign sat_up = &q;
   assign sat_dn = ~|q;
`else
   assign sat_up = 1'b0;
   assign sat_dn = 1'b0;
`endif
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   // next state: zero-step commands skip EXEC, EXEC leaves on its last step
   always_comb begin
      state_n = IDLE;
      state_n = state == IDLE ? (accept ? (direct ? DONE : EXEC) : IDLE) :
                state == EXEC ? (cnt_r == CW'(1) ? DONE : EXEC) : IDLE;
   end
   // command latch and step counter; single-step ops run exactly one EXEC cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         op_r <= OP_NOP;
         data_r <= '0;
         cnt_r <= '0;
      end else if (accept) begin
         op_r <= cmd_op;
         data_r <= cmd_data;
         cnt_r <= multi ? cmd_count : CW'(1);
      end else if (state == EXEC) cnt_r <= cnt_r - CW'(1);
   genvar i;
   generate
      for (i = 0; i < W; i++) begin : g_cell
         localparam logic [W-1:0] LOW = (W'(1) << i) - W'(1);
         logic [1:0] code;
         assign ones[i] = (q & LOW) == LOW;
         assign zeros[i] = (q & LOW) == '0;
         assign code = state != EXEC ? JK_HOLD :
                       op_r == OP_CLEAR ? JK_RST :
                       op_r == OP_LOAD ? (data_r[i] ? JK_SET : JK_RST) :
                       op_r == OP_TOGGLE ? (data_r[i] ? JK_TGL : JK_HOLD) :
                       op_r == OP_UP ? (ones[i] && !sat_up ? JK_TGL : JK_HOLD) :
                       op_r == OP_DOWN ? (zeros[i] && !sat_dn ? JK_TGL : JK_HOLD) : JK_HOLD;
         assign jk_mon[2*i+1:2*i] = code;
         jk_cell u_cell (
            .clk(clk),
            .rst(rst),
            .j(code[1]),
            .k(code[0]),
            .q(q[i]),
            .qbar(qbar[i])
         );
      end
   endgenerate
endmodule

// File: tb/tb_jk_seq_ctrl.sv
// tb_jk_seq_ctrl: scoreboard bench for jk_seq_ctrl; honours JK_SEQ_SAT_EN
module tb_jk_seq_ctrl;
   import jk_seq_pkg::*;
   localparam int W = 4;
   localparam int CW = 8;
`ifdef JK_SEQ_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [W-1:0] cmd_data = '0, q, qbar, mq = '0;
   logic [CW-1:0] cmd_count = '0;
   logic [2*W-1:0] jk_mon;
   logic busy, done, err;
   logic [W-1:0] q_q[$];
   logic [2*W-1:0] jk_q[$];
   logic err_q[$];
   int total = 0, bad = 0;
   bit was_exec = 1'b0;

   jk_seq_ctrl #(.W(W), .CW(CW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
      .q(q), .qbar(qbar), .jk_mon(jk_mon), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // cells whose value changes toggle, except LOAD/CLEAR which set/reset from the new value
   function automatic logic [2*W-1:0] jk_of(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] r;
      for (int i = 0; i < W; i++)
         r[2*i+:2] = (op == OP_CLEAR || op == OP_LOAD) ? (b[i] ? 2'b10 : 2'b01) : ((a[i] ^ b[i]) ? 2'b11 : 2'b00);
      return r;
   endfunction

   task automatic expect_cmd(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] c);
      logic [W-1:0] nq;
      int steps;
      steps = (op == OP_UP || op == OP_DOWN) ? int'(c) : (op == OP_CLEAR || op == OP_LOAD || op == OP_TOGGLE) ? 1 : 0;
      for (int s = 0; s < steps; s++) begin
         nq = op == OP_CLEAR ? '0 : op == OP_LOAD ? d : op == OP_TOGGLE ? mq ^ d :
              op == OP_UP ? ((SAT && mq == '1) ? mq : mq + 1'b1) : ((SAT && mq == '0) ? mq : mq - 1'b1);
         q_q.push_back(nq);
         jk_q.push_back(jk_of(op, mq, nq));
         mq = nq;
      end
      err_q.push_back(op > OP_TOGGLE);
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] c, input bit hold);
      int n;
      bit dir;
      dir = op == OP_NOP || op > OP_TOGGLE || ((op == OP_UP || op == OP_DOWN) && c == '0);
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk("ready_wait", cmd_ready, 1);
      expect_cmd(op, d, c);
      cmd_op = op; cmd_data = d; cmd_count = c; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("accept_busy", busy, 1);
      chk("accept_done", done, dir);
      n = 0;
      if (hold) while (!done && n < 50) begin @(negedge clk); n++; end
      cmd_valid = 1'b0;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk("ready_back", cmd_ready, 1);
      chk("q_left", q_q.size(), 0);
      chk("jk_left", jk_q.size(), 0);
      chk("err_left", err_q.size(), 0);
   endtask

   // scoreboard: jk during EXEC, q after each EXEC edge, err on done
   always @(negedge clk) begin
      logic [W-1:0] e, eb;
      bit in_exec;
      if (rst) was_exec = 1'b0;
      else begin
         if (was_exec) begin
            if (q_q.size() == 0) chk("q_extra", 1, 0);
            else begin
               e = q_q.pop_front();
               eb = ~e;
               chk("q", q, e);
               chk("qbar", qbar, eb);
            end
         end
         in_exec = busy && !done;
         if (in_exec) begin
            if (jk_q.size() == 0) chk("jk_extra", 1, 0);
            else chk("jk", jk_mon, jk_q.pop_front());
         end else chk("jk_idle", jk_mon, 0);
         if (was_exec && !in_exec) chk("done_after_exec", done, 1);
         if (done) begin
            if (err_q.size() == 0) chk("done_extra", 1, 0);
            else chk("err", err, err_q.pop_front());
         end else chk("err_nodone", err, 0);
         was_exec = in_exec;
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_q", q, 0);
      chk("rst_qbar", qbar, 4'hF);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_jk", jk_mon, 0);
      rst = 1'b0;
      @(negedge clk);
      issue(OP_LOAD, 4'b1010, 0, 0);
      issue(OP_LOAD, 4'b1110, 0, 0);
      issue(OP_UP, 0, 3, 0);
      issue(OP_LOAD, 4'b0001, 0, 0);
      issue(OP_DOWN, 0, 2, 0);
      issue(OP_LOAD, 4'b1111, 0, 0);
      issue(OP_TOGGLE, 4'b0110, 0, 0);
      issue(OP_UP, 0, 0, 0);
      issue(3'b111, 4'b0101, 5, 0);
      issue(3'b110, 0, 0, 0);
      issue(OP_NOP, 4'b1111, 0, 0);
      issue(OP_DOWN, 0, 0, 0);
      issue(OP_TOGGLE, 4'b1111, 0, 1);
      issue(OP_UP, 0, 5, 1);
      issue(OP_LOAD, 4'b0110, 0, 0);
      expect_cmd(OP_UP, 0, 10);
      cmd_op = OP_UP; cmd_count = 10; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_q", q, 0);
      chk("abort_qbar", qbar, 4'hF);
      chk("abort_ready", cmd_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_jk", jk_mon, 0);
      q_q.delete();
      jk_q.delete();
      err_q.delete();
      mq = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      issue(OP_CLEAR, 0, 0, 0);
      issue(OP_LOAD, 4'b0011, 0, 0);
      issue(OP_CLEAR, 4'b1111, 0, 0);
      issue(OP_DOWN, 0, 1, 0);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
